// File: rtl/adder_result_accumulator.sv
// Sums BLOCK_LEN adder results ({C_out,SUM}) into a saturating block total, then holds it for a consumer.
// Latency: a sample is visible in Acc_out one cycle after acceptance. Backpressure: no samples are taken while a result waits.
module adder_result_accumulator #(
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  input  logic [7:0]       i_sum,
  input  logic             i_c_out,
  output logic             o_in_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_acc_out,
  output logic             o_acc_ovf,
  output logic [7:0]       o_blk_cnt
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [7:0]       r_blk_cnt;

  logic [ACC_W-1:0] w_sample;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_carry;
  logic [ACC_W-1:0] w_sum_sat;
  logic             w_accept;
  logic             w_last;

  assign w_sample  = {{(ACC_W-9){1'b0}}, i_c_out, i_sum};
  assign w_sum_ext = {1'b0, r_acc} + {1'b0, w_sample};
  assign w_carry   = w_sum_ext[ACC_W];
  assign w_sum_sat = w_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  assign w_accept  = (r_state == ACCUM) && i_in_valid;
  assign w_last    = (r_blk_cnt == 8'(BLOCK_LEN - 1));

  // Handshake flags come straight from the state register so no input can ripple to them.
  assign o_in_ready  = (r_state == ACCUM);
  assign o_out_valid = (r_state == HOLD);
  assign o_acc_out   = r_acc;
  assign o_acc_ovf   = r_ovf;
  assign o_blk_cnt   = r_blk_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_blk_cnt <= '0;
    end else if (i_clear) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_blk_cnt <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc     <= w_sum_sat;
            r_ovf     <= r_ovf | w_carry;
            r_blk_cnt <= r_blk_cnt + 8'd1;
            if (w_last) r_state <= HOLD;
          end
        end
        HOLD: begin
          if (i_out_ready) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_blk_cnt <= '0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Directed bench: a 16-bit and a 10-bit accumulator share one stimulus stream.
module tb_adder_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  sum = 8'd0;
  logic        c_out = 1'b0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_ovf;
  logic [15:0] a_acc;
  logic [7:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [9:0]  b_acc;
  logic [7:0]  b_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_result_accumulator #(.ACC_W(16), .BLOCK_LEN(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid),
    .i_sum(sum), .i_c_out(c_out), .o_in_ready(a_in_ready), .o_out_valid(a_out_valid),
    .i_out_ready(out_ready), .o_acc_out(a_acc), .o_acc_ovf(a_ovf), .o_blk_cnt(a_cnt)
  );

  adder_result_accumulator #(.ACC_W(10), .BLOCK_LEN(4)) dut10 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(in_valid),
    .i_sum(sum), .i_c_out(c_out), .o_in_ready(b_in_ready), .o_out_valid(b_out_valid),
    .i_out_ready(out_ready), .o_acc_out(b_acc), .o_acc_ovf(b_ovf), .o_blk_cnt(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [8:0] s);
    in_valid = v;
    {c_out, sum} = s;
  endtask

  initial begin
    // Reset asserted mid-cycle, before any edge has initialised the state.
    #13 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_acc", 32'(a_acc), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    #2 rst_n = 1'b1;
    tick();

    // Nominal block 2 + 17 + 24 + 511 = 554.
    drive(1'b1, 9'd2);   tick();
    chk("nom_acc1", 32'(a_acc), 32'd2);
    chk("nom_cnt1", 32'(a_cnt), 32'd1);
    drive(1'b1, 9'd17);  tick();
    chk("nom_acc2", 32'(a_acc), 32'd19);
    drive(1'b1, 9'd24);  tick();
    chk("nom_acc3", 32'(a_acc), 32'd43);
    chk("nom_rdy3", 32'(a_in_ready), 32'd1);
    drive(1'b1, 9'd511); tick();
    chk("nom_out_valid", 32'(a_out_valid), 32'd1);
    chk("nom_in_ready", 32'(a_in_ready), 32'd0);
    chk("nom_acc", 32'(a_acc), 32'd554);
    chk("nom_ovf", 32'(a_ovf), 32'd0);
    chk("nom_cnt", 32'(a_cnt), 32'd4);

    // Backpressure with samples still offered.
    drive(1'b1, 9'd5);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_acc", 32'(a_acc), 32'd554);
      chk("bp_cnt", 32'(a_cnt), 32'd4);
      chk("bp_in_ready", 32'(a_in_ready), 32'd0);
      chk("bp_out_valid", 32'(a_out_valid), 32'd1);
    end
    drive(1'b0, 9'd0);
    out_ready = 1'b1;
    tick();
    chk("hs_out_valid", 32'(a_out_valid), 32'd0);
    chk("hs_acc", 32'(a_acc), 32'd0);
    chk("hs_cnt", 32'(a_cnt), 32'd0);
    // Out_ready stays high in ACCUM: must not disturb accumulation.
    drive(1'b1, 9'd511); tick();
    chk("sat_acc1_w10", 32'(b_acc), 32'd511);
    out_ready = 1'b0;
    tick();
    chk("sat_acc2_w10", 32'(b_acc), 32'd1022);
    chk("sat_ovf2_w10", 32'(b_ovf), 32'd0);
    tick();
    chk("sat_acc3_w10", 32'(b_acc), 32'd1023);
    chk("sat_ovf3_w10", 32'(b_ovf), 32'd1);
    tick();
    drive(1'b0, 9'd0);
    chk("sat_acc_w10", 32'(b_acc), 32'd1023);
    chk("sat_ovf_w10", 32'(b_ovf), 32'd1);
    chk("sat_valid_w10", 32'(b_out_valid), 32'd1);
    chk("sat_acc_w16", 32'(a_acc), 32'd2044);
    chk("sat_ovf_w16", 32'(a_ovf), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("sat_ovf_clr_w10", 32'(b_ovf), 32'd0);
    chk("sat_acc_clr_w10", 32'(b_acc), 32'd0);

    // Clear mid-block discards the sample offered alongside it.
    drive(1'b1, 9'd100); tick(); tick();
    chk("clr_pre_acc", 32'(a_acc), 32'd200);
    chk("clr_pre_cnt", 32'(a_cnt), 32'd2);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_acc", 32'(a_acc), 32'd0);
    chk("clr_cnt", 32'(a_cnt), 32'd0);
    drive(1'b1, 9'd1);
    tick(); tick(); tick();
    chk("clr_partial_valid", 32'(a_out_valid), 32'd0);
    tick();
    drive(1'b0, 9'd0);
    chk("clr_blk_valid", 32'(a_out_valid), 32'd1);
    chk("clr_blk_acc", 32'(a_acc), 32'd4);
    chk("clr_blk_cnt", 32'(a_cnt), 32'd4);

    // Clear in HOLD wins over a simultaneous handshake and returns to ACCUM.
    clear = 1'b1; out_ready = 1'b1; tick(); clear = 1'b0; out_ready = 1'b0;
    chk("clrh_valid", 32'(a_out_valid), 32'd0);
    chk("clrh_acc", 32'(a_acc), 32'd0);

    // Reset during HOLD.
    drive(1'b1, 9'd3);
    tick(); tick(); tick(); tick();
    drive(1'b0, 9'd0);
    chk("rh_pre_valid", 32'(a_out_valid), 32'd1);
    chk("rh_pre_acc", 32'(a_acc), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("rh_valid", 32'(a_out_valid), 32'd0);
    chk("rh_ready", 32'(a_in_ready), 32'd1);
    chk("rh_acc", 32'(a_acc), 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 9'd7);
    tick();
    chk("rh_first_acc", 32'(a_acc), 32'd7);
    chk("rh_first_cnt", 32'(a_cnt), 32'd1);
    tick(); tick(); tick();
    drive(1'b0, 9'd0);
    chk("rh_blk_acc", 32'(a_acc), 32'd28);
    chk("rh_blk_valid", 32'(a_out_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_result_accumulator.md
ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

Interface
REQ-001 The block SHALL sit directly downstream of the registered 8-bit full adder and consume its SUM/C_out result stream.
REQ-002 Parameter ACC_W SHALL default to 16 and set the accumulator width (legal 10..32).
REQ-003 Parameter BLOCK_LEN SHALL default to 4 and set the samples per block (legal 1..255).
REQ-004 Clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Clear  input  1  synchronous abort of the current block.
REQ-007 In_valid  input  1  SUM/C_out carry a valid result this cycle.
REQ-008 SUM  input  8  adder sum bits.
REQ-009 C_out  input  1  adder carry-out.
REQ-010 In_ready  output  1  block accepts a sample this cycle.
REQ-011 Out_valid  output  1  block result available.
REQ-012 Out_ready  input  1  consumer accepts the result.
REQ-013 Acc_out  output  ACC_W  accumulated block total.
REQ-014 Acc_ovf  output  1  block total saturated.
REQ-015 Blk_cnt  output  8  samples accepted in the current block.

Function
REQ-016 Each sample value SHALL be {C_out, SUM}, a 9-bit unsigned quantity zero-extended to ACC_W.
REQ-017 The FSM SHALL have two states: ACCUM and HOLD.
REQ-018 In ACCUM, In_ready SHALL be 1 and Out_valid SHALL be 0.
REQ-019 In HOLD, In_ready SHALL be 0 and Out_valid SHALL be 1.
REQ-020 In_ready and Out_valid SHALL be decoded from the registered state only, with no combinational path from any input.
REQ-021 A sample SHALL be accepted only on a cycle where In_valid=1 and In_ready=1; one sample per cycle SHALL be sustainable in ACCUM.
REQ-022 On acceptance, the accumulator SHALL add the sample and Blk_cnt SHALL increment by 1, both visible the next cycle.
REQ-023 When the accepted sample is the BLOCK_LEN-th of the block, the FSM SHALL enter HOLD on the next cycle with Acc_out equal to the full block total.
REQ-024 Addition SHALL saturate at 2^ACC_W-1; on any saturation Acc_ovf SHALL set and stay set until the block ends.
REQ-025 In HOLD, Acc_out, Acc_ovf and Blk_cnt SHALL hold stable until Out_valid=1 and Out_ready=1.
REQ-026 On the HOLD handshake, the accumulator, Acc_ovf and Blk_cnt SHALL clear and the FSM SHALL return to ACCUM on the next cycle.
REQ-027 Samples presented while in HOLD SHALL be ignored (not accepted).
REQ-028 Out_ready SHALL be ignored while in ACCUM.
REQ-029 Clear=1 SHALL, at the next edge, zero the accumulator, Acc_ovf and Blk_cnt and force ACCUM, taking priority over any input or output handshake in the same cycle; the sample and/or result in that cycle SHALL be discarded.
REQ-030 While in ACCUM, Acc_out SHALL show the running partial total.

Reset
REQ-031 Reset_n=0 SHALL immediately force state ACCUM, Acc_out=0, Acc_ovf=0, Blk_cnt=0, Out_valid=0 and In_ready=1, regardless of Clock.
REQ-032 Reset assertion during HOLD SHALL drop Out_valid asynchronously and discard the pending result.
REQ-033 Release of Reset_n SHALL be followed by normal acceptance on the first rising edge after release.

Verification (ACC_W=16, BLOCK_LEN=4 unless stated)
REQ-034 Reset: assert Reset_n=0 mid-cycle -> outputs go to reset values at once; In_ready=1 and Out_valid=0.
REQ-035 Nominal block: samples 2, 17, 24 ({0,0x02}, {0,0x11}, {0,0x18}) then {1,0xFF}=511 on consecutive cycles -> the next cycle has Out_valid=1, Acc_out=554, Acc_ovf=0 and Blk_cnt=4.
REQ-036 Backpressure: hold Out_ready=0 for 5 cycles in HOLD with In_valid=1 -> Acc_out stays 554, In_ready=0 and no sample is accepted; Out_ready=1 -> the next cycle returns to ACCUM with Acc_out=0.
REQ-037 Saturation (ACC_W=10): four samples of 511 -> Acc_out=1023 and Acc_ovf=1; after the handshake, Acc_ovf=0.
REQ-038 Clear mid-block: accept 2 samples of 100, pulse Clear, then accept 4 samples of 1 -> the result is Acc_out=4.
REQ-039 Reset in HOLD: with Out_valid=1, pulse Reset_n low -> Out_valid=0 immediately, and the next block accumulates from 0.
